// File: rtl/blink_led_pkg.sv
// Shared definitions for the LED blinker: default phase lengths, phase
// encoding and the counter-width helper used by the top and its counter.
package blink_led_pkg;

    localparam int DEF_ON_CYCLES  = 50;
    localparam int DEF_OFF_CYCLES = 50;

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } phase_t;

    // Wide enough to hold the larger terminal count (max-1), never below 1 bit.
    function automatic int cnt_width(input int on_cycles, input int off_cycles);
        int longest;
        longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/blink_phase_counter.sv
// Phase-length counter: counts up from zero, flags the terminal count against
// a limit chosen at run time, and returns to zero on terminal count or srst.
module blink_phase_counter
    import blink_led_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [CNT_W-1:0] last_val,
    output logic             tc
);

    // Power-up value matches the reset value so the blinker starts defined.
    logic [CNT_W-1:0] cnt_reg = '0;
    logic [CNT_W-1:0] cnt_next;

    assign tc = (cnt_reg == last_val);

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (tc) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/blink_led.sv
// Free-running LED blinker: OFF for OFF_CYCLES, ON for ON_CYCLES, repeating.
// The phase and LED drive are registered here; the cycle count lives in the counter.
module blink_led
    import blink_led_pkg::*;
#(
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    output logic led_out
);

    localparam int CNT_W = cnt_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    generate
        if (ON_CYCLES < 1 || OFF_CYCLES < 1) begin : g_bad_params
            $fatal(1, "blink_led: ON_CYCLES and OFF_CYCLES must both be >= 1");
        end
    endgenerate

    phase_t           phase_reg = PH_OFF;
    phase_t           phase_next;
    logic             led_reg   = ACTIVE_LOW;
    logic             led_next;
    logic [CNT_W-1:0] last_val;
    logic             tc;

    // Terminal count always compares against the limit of the current phase.
    assign last_val = (phase_reg == PH_ON) ? ON_LAST : OFF_LAST;

    blink_phase_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .srst     (reset),
        .last_val (last_val),
        .tc       (tc)
    );

    always_comb begin
        phase_next = phase_reg;
        led_next   = led_reg;
        if (tc) begin
            phase_next = (phase_reg == PH_ON) ? PH_OFF : PH_ON;
            led_next   = (phase_next == PH_ON) ^ ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg <= PH_OFF;
            led_reg   <= ACTIVE_LOW;
        end else begin
            phase_reg <= phase_next;
            led_reg   <= led_next;
        end
    end

    assign led_out = led_reg;

endmodule

// File: tb/tb_blink_led.sv
// Bench for blink_led: several parameterisations share a randomised reset and
// are compared every cycle against an edges-since-reset model of the waveform.
module tb_blink_led;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic reset_never = 1'b0;

    logic led_def, led_37, led_al, led_11, led_14, led_nr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int k_rst    = 0;   // edges since the last reset edge
    int k_nr     = 0;   // edges since time zero (instance never reset)

    always #50 clk = ~clk;

    blink_led u_def (.clk(clk), .reset(reset), .led_out(led_def));
    blink_led #(.OFF_CYCLES(7), .ON_CYCLES(3)) u_37 (.clk(clk), .reset(reset), .led_out(led_37));
    blink_led #(.ACTIVE_LOW(1'b1)) u_al (.clk(clk), .reset(reset), .led_out(led_al));
    blink_led #(.OFF_CYCLES(1), .ON_CYCLES(1)) u_11 (.clk(clk), .reset(reset), .led_out(led_11));
    blink_led #(.OFF_CYCLES(4), .ON_CYCLES(1)) u_14 (.clk(clk), .reset(reset), .led_out(led_14));
    blink_led u_nr (.clk(clk), .reset(reset_never), .led_out(led_nr));

    // After k edges of free running the LED is lit iff k lands in the ON
    // part of the period, i.e. position within period >= off.
    function automatic logic model_led(input int k, input int on_c, input int off_c, input bit al);
        logic lit;
        lit = ((k % (on_c + off_c)) >= off_c);
        return lit ^ al;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        check("def",      {31'd0, led_def}, {31'd0, model_led(k_rst, 50, 50, 1'b0)});
        check("on3_off7", {31'd0, led_37},  {31'd0, model_led(k_rst, 3, 7, 1'b0)});
        check("act_low",  {31'd0, led_al},  {31'd0, model_led(k_rst, 50, 50, 1'b1)});
        check("on1_off1", {31'd0, led_11},  {31'd0, model_led(k_rst, 1, 1, 1'b0)});
        check("on1_off4", {31'd0, led_14},  {31'd0, model_led(k_rst, 1, 4, 1'b0)});
        check("no_reset", {31'd0, led_nr},  {31'd0, model_led(k_nr, 50, 50, 1'b0)});
    endtask

    // Apply one reset value across one rising edge, advance the model, compare.
    task automatic step(input logic r);
        reset = r;
        @(posedge clk);
        #1;
        cyc++;
        k_nr++;
        if (r) k_rst = 0;
        else   k_rst++;
        check_all();
    endtask

    initial begin
        int toggles;
        logic prev;
        int gap;
        int len;

        #1;
        check("pwrup_known", {31'd0, $isunknown(led_nr)}, 32'd0);
        check_all();

        step(1'b1);
        step(1'b1);

        // 500 free-running cycles with defaults must show exactly 10 edges.
        toggles = 0;
        prev = led_def;
        for (int i = 0; i < 500; i++) begin
            step(1'b0);
            if (led_def !== prev) toggles++;
            prev = led_def;
        end
        check("toggles_500", toggles, 32'd10);

        // Reset lands in the middle of the default ON phase (edge 60).
        step(1'b1);
        for (int i = 0; i < 59; i++) step(1'b0);
        check("mid_on_lit", {31'd0, led_def}, 32'd1);
        step(1'b1);
        for (int i = 0; i < 60; i++) step(1'b0);

        // Random reset pulses of random length at random gaps.
        for (int p = 0; p < 20; p++) begin
            gap = $urandom_range(1, 250);
            len = $urandom_range(1, 3);
            for (int i = 0; i < gap; i++) step(1'b0);
            for (int i = 0; i < len; i++) step(1'b1);
        end
        for (int i = 0; i < 120; i++) step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/blink_led.md
Name: blink_led

Overview:
- Free-running LED blinker that toggles a single output with programmable ON/OFF durations measured in clock cycles.
- Leaf block at board/top level; drives an LED pin or serves as a heartbeat/alive indicator.
- Pure clocked counter plus phase register; no inputs other than clock and reset.

Parameters:
- OFF_CYCLES, 50, clock cycles the LED spends in the OFF phase; must be >= 1.
- ON_CYCLES, 50, clock cycles the LED spends in the ON phase; must be >= 1.
- ACTIVE_LOW, 0, when 1, led_out is inverted (LED lit = 0); internal phase logic is unchanged.
- CNT_W, derived as $clog2(max(ON_CYCLES, OFF_CYCLES)+1) and not overridable; phase counter width.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
- led_out  output  1  registered LED drive; 1 = lit when ACTIVE_LOW=0.

Behaviour:
- One clock, clk; reset is synchronous and active-high. No asynchronous paths; led_out comes directly from a flop.
- State: phase register (OFF=0, ON=1); counter cnt[CNT_W-1:0].
- Reset (reset=1 at a rising edge): phase=OFF, cnt=0, led_out=ACTIVE_LOW (LED dark). Reset overrides counting on the same edge.
- Power-up: all flops carry initial values equal to their reset values. Simulation and FPGA start defined even if reset is never asserted.
- Each non-reset edge in phase P with limit L (OFF_CYCLES or ON_CYCLES):
  - if cnt == L-1: cnt <= 0, phase <= ~P, led_out <= (~P) ^ ACTIVE_LOW;
  - else: cnt <= cnt+1; phase and led_out hold.
- Timing (edges counted after reset release or power-up, edge 1 = first active edge):
  - led_out turns ON at edge OFF_CYCLES.
  - led_out turns OFF at edge OFF_CYCLES+ON_CYCLES.
  - Period is ON_CYCLES+OFF_CYCLES cycles. Duty is ON_CYCLES/(ON_CYCLES+OFF_CYCLES).
- Default timing: toggles every 50 cycles, period 100 cycles. At a 100 ns clock this is a 10 µs blink, and 500 cycles show 10 toggles.
- Boundary conditions:
  - ON_CYCLES=1: a one-cycle ON pulse each period.
  - ON_CYCLES=OFF_CYCLES=1: led_out toggles every cycle.
  - cnt never exceeds L-1, so there is no wrap-around beyond the terminal count.
  - Terminal-count comparison uses the limit of the current phase only.
- Reset mid-phase, ON or OFF: on the next edge, returns to OFF with cnt=0. The full OFF_CYCLES interval restarts; no residual count is carried over.
- Reset held high for multiple cycles: outputs stay at reset values.
- Elaboration check: fatal error if ON_CYCLES < 1 or OFF_CYCLES < 1.

Decomposition:
- Shared package blink_led_pkg:
  - default constants DEF_ON_CYCLES=50 and DEF_OFF_CYCLES=50;
  - phase enum typedef {PH_OFF, PH_ON};
  - width helper function cnt_width(on, off).
- Natural sub-module: blink_phase_counter.
  - Holds the parameterized CNT_W counter with synchronous clear and a terminal-count output against a runtime-selected limit.
  - blink_led instantiates it and owns the phase/led_out flops.

Test Plan:
- Defaults, 100 ns clk, reset high for 2 edges, then low for 500 cycles:
  - led_out=0 during reset;
  - 0->1 at edge 50, 1->0 at edge 100;
  - exactly 10 transitions in 500 cycles.
- No reset ever asserted, defaults: led_out=0 at time 0, never X; first rise at edge 50.
- ON_CYCLES=3, OFF_CYCLES=7: led_out high for exactly 3 cycles, low for 7, period 10; rise at edge 7, fall at edge 10.
- Reset asserted mid-ON (edge 60, defaults) for one cycle: led_out=0 on that edge; next rise 50 edges after reset release.
- ACTIVE_LOW=1, defaults: led_out=1 in reset and OFF phase; drops to 0 at edge 50.
- ON_CYCLES=OFF_CYCLES=1: led_out toggles every edge after reset release (0,1,0,1...).
